// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper planner and the phase sequencer:
// FSM state encodings, direction encoding and the speed word width.
package stepper_pkg;

  localparam int SPEED_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEL  = 2'd1;
  localparam logic [1:0] ST_CRUISE = 2'd2;
  localparam logic [1:0] ST_DECEL  = 2'd3;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  // Magnitude of a signed 16-bit step count; -32768 maps to 16'h8000.
  function automatic logic [15:0] abs_steps(input logic [15:0] s);
    return s[15] ? (~s + 16'd1) : s;
  endfunction

endpackage

// File: rtl/planner_tick_gen.sv
// Free-running prescaler: tick_o is high for one clock every TICK_DIV clocks.
module planner_tick_gen #(
  parameter int TICK_DIV = 500
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap the counter at TICK_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/stepper_move_planner.sv
// Trapezoidal move planner: takes a relative move command and emits step
// pulses from a phase accumulator whose rate ramps between VMIN and vmax.
module stepper_move_planner
  import stepper_pkg::*;
#(
  parameter int TICK_DIV   = 500,
  parameter int ACC_W      = 16,
  parameter int RAMP_TICKS = 1000,
  parameter int VMIN       = 8,
  parameter int POS_W      = 24
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [15:0]        cmd_steps,
  input  logic [SPEED_W-1:0]        cmd_vmax,
  input  logic                      abort,
  output logic                      step_pulse,
  output logic                      direccion,
  output logic [SPEED_W-1:0]        velocidad,
  output logic                      busy,
  output logic                      done,
  output logic signed [POS_W-1:0]   position
);

  localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [RAMP_W-1:0]      RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);
  localparam logic [SPEED_W-1:0]     VMIN_V    = SPEED_W'(VMIN);
  localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);

  // Clamp the requested peak speed up to the start/stop speed.
  function automatic logic [SPEED_W-1:0] sat_vmax(input logic [SPEED_W-1:0] v);
    return (v < VMIN_V) ? VMIN_V : v;
  endfunction

  function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

  logic                      tick;
  logic [1:0]                state_q, state_d;
  logic [15:0]               remaining_q, remaining_d;
  logic [15:0]               accel_steps_q, accel_steps_d;
  logic [SPEED_W-1:0]        vmax_q, vmax_d, vel_q, vel_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [RAMP_W-1:0]         ramp_q, ramp_d;
  logic                      dir_q, dir_d, step_q, step_d, done_q, done_d;
  logic signed [POS_W-1:0]   pos_q, pos_d;
  logic [ACC_W:0]            acc_sum;
  logic                      step_now, ramp_hit;
  logic [15:0]               rem_after, accel_after, rem_abort;

  planner_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clock),
    .rst_i  (rst),
    .tick_o (tick)
  );

  // Next-state logic: command latch, stepping, ramping, abort and completion.
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    accel_steps_d = accel_steps_q;
    vmax_d        = vmax_q;
    vel_d         = vel_q;
    acc_d         = acc_q;
    ramp_d        = ramp_q;
    dir_d         = dir_q;
    pos_d         = pos_q;
    step_d        = 1'b0;
    done_d        = 1'b0;

    acc_sum     = {1'b0, acc_q} + (ACC_W+1)'(vel_q);
    step_now    = (state_q != ST_IDLE) && tick && acc_sum[ACC_W];
    ramp_hit    = tick && (ramp_q == RAMP_LAST);
    rem_after   = remaining_q - 16'(step_now);
    accel_after = accel_steps_q + 16'(step_now && (state_q == ST_ACCEL));
    rem_abort   = min16(rem_after, accel_after);

    if (state_q == ST_IDLE) begin
      if (cmd_valid) begin
        if (cmd_steps == '0 || cmd_vmax == '0) begin
          done_d = 1'b1;
        end else begin
          remaining_d   = abs_steps(cmd_steps);
          dir_d         = cmd_steps[15] ? DIR_NEG : DIR_POS;
          vmax_d        = sat_vmax(cmd_vmax);
          vel_d         = VMIN_V;
          acc_d         = '0;
          accel_steps_d = '0;
          ramp_d        = '0;
          state_d       = ST_ACCEL;
        end
      end
    end else if (remaining_q == '0) begin
      state_d = ST_IDLE;
      vel_d   = '0;
      done_d  = 1'b1;
    end else begin
      if (tick) acc_d = acc_sum[ACC_W-1:0];
      if (step_now) begin
        step_d      = 1'b1;
        remaining_d = rem_after;
        pos_d       = (dir_q == DIR_NEG) ? pos_q - POS_ONE : pos_q + POS_ONE;
      end
      accel_steps_d = accel_after;

      case (state_q)
        ST_ACCEL: begin
          // Running out of distance outranks reaching peak speed.
          if (remaining_q <= accel_steps_q) begin
            state_d = ST_DECEL;
            ramp_d  = '0;
          end else if (vel_q >= vmax_q) begin
            state_d = ST_CRUISE;
            ramp_d  = '0;
          end else if (tick) begin
            if (ramp_hit) begin
              vel_d  = vel_q + 1'b1;
              ramp_d = '0;
            end else begin
              ramp_d = ramp_q + 1'b1;
            end
          end
        end
        ST_CRUISE: begin
          ramp_d = '0;
          if (remaining_q <= accel_steps_q) state_d = ST_DECEL;
        end
        default: begin
          if (tick) begin
            if (ramp_hit) begin
              if (vel_q > VMIN_V) vel_d = vel_q - 1'b1;
              ramp_d = '0;
            end else begin
              ramp_d = ramp_q + 1'b1;
            end
          end
        end
      endcase

      // Controlled stop: only as many steps as it took to get up to speed.
      if (abort && (state_q == ST_ACCEL || state_q == ST_CRUISE)) begin
        state_d     = ST_DECEL;
        ramp_d      = '0;
        remaining_d = rem_abort;
        vel_d       = vel_q;
        if (rem_abort == '0) begin
          state_d = ST_IDLE;
          vel_d   = '0;
          done_d  = 1'b1;
        end
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      remaining_q   <= '0;
      accel_steps_q <= '0;
      vmax_q        <= '0;
      vel_q         <= '0;
      acc_q         <= '0;
      ramp_q        <= '0;
      dir_q         <= DIR_POS;
      pos_q         <= '0;
      step_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      accel_steps_q <= accel_steps_d;
      vmax_q        <= vmax_d;
      vel_q         <= vel_d;
      acc_q         <= acc_d;
      ramp_q        <= ramp_d;
      dir_q         <= dir_d;
      pos_q         <= pos_d;
      step_q        <= step_d;
      done_q        <= done_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign step_pulse = step_q;
  assign direccion  = dir_q;
  assign velocidad  = vel_q;
  assign done       = done_q;
  assign position   = pos_q;

endmodule

// File: tb/tb_stepper_move_planner.sv
// Directed bench for stepper_move_planner. Instance A uses VMIN=128,
// instance B uses VMIN=1; both run with TICK_DIV=1, ACC_W=8, RAMP_TICKS=1.
module tb_stepper_move_planner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               a_valid = 1'b0, b_valid = 1'b0;
  logic signed [15:0] cmd_steps = '0;
  logic [7:0]         cmd_vmax = '0;
  logic               abort = 1'b0;

  logic               a_ready, a_step, a_dir, a_busy, a_done;
  logic [7:0]         a_vel;
  logic signed [23:0] a_pos;
  logic               b_ready, b_step, b_dir, b_busy, b_done;
  logic [7:0]         b_vel;
  logic signed [23:0] b_pos;

  int errors = 0;
  int checks = 0;

  stepper_move_planner #(.TICK_DIV(1), .ACC_W(8), .RAMP_TICKS(1), .VMIN(128), .POS_W(24)) dut_a (
    .clock(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_steps(cmd_steps), .cmd_vmax(cmd_vmax), .abort(abort),
    .step_pulse(a_step), .direccion(a_dir), .velocidad(a_vel),
    .busy(a_busy), .done(a_done), .position(a_pos));

  stepper_move_planner #(.TICK_DIV(1), .ACC_W(8), .RAMP_TICKS(1), .VMIN(1), .POS_W(24)) dut_b (
    .clock(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_steps(cmd_steps), .cmd_vmax(cmd_vmax), .abort(abort),
    .step_pulse(b_step), .direccion(b_dir), .velocidad(b_vel),
    .busy(b_busy), .done(b_done), .position(b_pos));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit use_b, input logic signed [15:0] s, input logic [7:0] v);
    cmd_steps = s;
    cmd_vmax  = v;
    if (use_b) b_valid = 1'b1; else a_valid = 1'b1;
    cyc();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Runs until done (bounded), then 3 extra cycles; gathers pulse/done stats.
  task automatic run_until_done(input bit use_b, input int budget, output int pulses,
                                output int dones, output int first_pulse,
                                output int last_pulse, output int done_at, output int bad_gap);
    int c;
    pulses = 0; dones = 0; first_pulse = -1; last_pulse = -1; done_at = -1; bad_gap = 0;
    c = 0;
    while (c < budget + 3 && !(done_at >= 0 && c >= done_at + 3)) begin
      c++;
      cyc();
      if (use_b ? b_step : a_step) begin
        if (last_pulse >= 0 && c - last_pulse != 2) bad_gap++;
        if (first_pulse < 0) first_pulse = c;
        last_pulse = c;
        pulses++;
      end
      if (use_b ? b_done : a_done) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_ready); end
    checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0/0", a_busy, b_busy); end
    checks++; if ({a_step, a_dir, a_done} !== 3'b000) begin errors++; $display("FAIL reset_step_dir_done: got %b want 000", {a_step, a_dir, a_done}); end
    checks++; if (a_vel !== 8'd0) begin errors++; $display("FAIL reset_vel: got %0d want 0", a_vel); end
    checks++; if (a_pos !== 24'sd0 || b_pos !== 24'sd0) begin errors++; $display("FAIL reset_pos: got %0h/%0h want 0/0", a_pos, b_pos); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_positive_move();
    int p, d, f, l, da, g;
    send(1'b0, 16'sd10, 8'd128);
    checks++; if (a_busy !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL pos_busy_ready: got %b/%b want 1/0", a_busy, a_ready); end
    checks++; if (a_vel !== 8'd128) begin errors++; $display("FAIL pos_start_vel: got %0d want 128", a_vel); end
    checks++; if (a_dir !== 1'b0) begin errors++; $display("FAIL pos_dir: got %b want 0", a_dir); end
    run_until_done(1'b0, 200, p, d, f, l, da, g);
    checks++; if (p !== 10) begin errors++; $display("FAIL pos_pulses: got %0d want 10", p); end
    checks++; if (f !== 2) begin errors++; $display("FAIL pos_first_pulse: got cycle %0d want 2", f); end
    checks++; if (g !== 0) begin errors++; $display("FAIL pos_pulse_gap: got %0d bad gaps want 0", g); end
    checks++; if (d !== 1) begin errors++; $display("FAIL pos_done_count: got %0d want 1", d); end
    checks++; if (da !== l + 1) begin errors++; $display("FAIL pos_done_timing: got cycle %0d want %0d", da, l + 1); end
    checks++; if (a_pos !== 24'sd10) begin errors++; $display("FAIL pos_position: got %0d want 10", a_pos); end
    checks++; if (a_busy !== 1'b0 || a_ready !== 1'b1 || a_vel !== 8'd0) begin errors++; $display("FAIL pos_idle_after: got busy=%b ready=%b vel=%0d want 0 1 0", a_busy, a_ready, a_vel); end
  endtask

  task automatic test_negative_move();
    int p, d, f, l, da, g;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    send(1'b0, -16'sd5, 8'd128);
    checks++; if (a_dir !== 1'b1) begin errors++; $display("FAIL neg_dir: got %b want 1", a_dir); end
    run_until_done(1'b0, 200, p, d, f, l, da, g);
    checks++; if (p !== 5) begin errors++; $display("FAIL neg_pulses: got %0d want 5", p); end
    checks++; if (d !== 1) begin errors++; $display("FAIL neg_done_count: got %0d want 1", d); end
    checks++; if (a_pos !== 24'shFFFFFB) begin errors++; $display("FAIL neg_position: got %0h want fffffb", a_pos); end
    checks++; if (a_dir !== 1'b1) begin errors++; $display("FAIL neg_dir_hold: got %b want 1", a_dir); end
  endtask

  task automatic test_zero_move();
    send(1'b0, 16'sd0, 8'd50);
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", a_done); end
    checks++; if (a_busy !== 1'b0 || a_ready !== 1'b1 || a_step !== 1'b0) begin errors++; $display("FAIL zero_idle: got busy=%b ready=%b step=%b want 0 1 0", a_busy, a_ready, a_step); end
    cyc();
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", a_done); end
    checks++; if (a_pos !== 24'shFFFFFB) begin errors++; $display("FAIL zero_position: got %0h want fffffb", a_pos); end
    send(1'b0, 16'sd7, 8'd0);
    checks++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL zero_vmax: got done=%b busy=%b want 1 0", a_done, a_busy); end
    cyc();
  endtask

  task automatic test_profile();
    int p = 0, d = 0, range_bad = 0, rise_after_fall = 0, jumps = 0, c = 0;
    int peak = 0;
    bit falling = 0, finished = 0;
    logic [7:0] prev;
    send(1'b1, 16'sd100, 8'd200);
    checks++; if (b_vel !== 8'd1) begin errors++; $display("FAIL prof_start_vel: got %0d want 1", b_vel); end
    prev = b_vel;
    while (!finished && c < 20000) begin
      c++;
      cyc();
      if (b_step) p++;
      if (b_done) begin d++; finished = 1; end
      if (b_busy) begin
        if (b_vel < 8'd1 || b_vel > 8'd200) range_bad++;
        if (b_vel > prev && falling) rise_after_fall++;
        if (b_vel < prev) falling = 1;
        if ((b_vel > prev && b_vel - prev > 1) || (prev > b_vel && prev - b_vel > 1)) jumps++;
        if (int'(b_vel) > peak) peak = int'(b_vel);
        prev = b_vel;
      end
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (b_step) p++;
      if (b_done) d++;
    end
    checks++; if (p !== 100) begin errors++; $display("FAIL prof_pulses: got %0d want 100", p); end
    checks++; if (d !== 1) begin errors++; $display("FAIL prof_done_count: got %0d want 1", d); end
    checks++; if (range_bad !== 0) begin errors++; $display("FAIL prof_vel_range: got %0d out-of-range samples want 0", range_bad); end
    checks++; if (rise_after_fall !== 0 || jumps !== 0) begin errors++; $display("FAIL prof_shape: got rise_after_fall=%0d jumps=%0d want 0 0", rise_after_fall, jumps); end
    checks++; if (peak <= 1 || !falling) begin errors++; $display("FAIL prof_trapezoid: got peak=%0d falling=%b want peak>1 falling=1", peak, falling); end
    checks++; if (b_vel !== 8'd0 || b_busy !== 1'b0) begin errors++; $display("FAIL prof_idle_after: got vel=%0d busy=%b want 0 0", b_vel, b_busy); end
    checks++; if (b_pos !== 24'sd100) begin errors++; $display("FAIL prof_position: got %0d want 100", b_pos); end
  endtask

  task automatic test_abort();
    int pb = 0, pa = 0, d = 0, c = 0;
    bit reached = 0, finished = 0;
    logic signed [23:0] exp_pos;
    send(1'b1, 16'sd30000, 8'd100);
    while (!reached && c < 1000) begin
      c++;
      cyc();
      if (b_step) pb++;
      if (b_vel == 8'd100) reached = 1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL abort_reach_vmax: got vel=%0d want 100", b_vel); end
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (b_step) pb++;
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    if (b_step) pb++;
    checks++; if (b_vel !== 8'd100 || b_busy !== 1'b1) begin errors++; $display("FAIL abort_first_cycle: got vel=%0d busy=%b want 100 1", b_vel, b_busy); end
    cyc();
    if (b_step) pa++;
    checks++; if (b_vel !== 8'd99) begin errors++; $display("FAIL abort_decel_start: got vel=%0d want 99", b_vel); end
    c = 0;
    while (!finished && c < 20000) begin
      c++;
      cyc();
      if (b_step) pa++;
      if (b_done) begin d++; finished = 1; end
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (b_step) pa++;
      if (b_done) d++;
    end
    checks++; if (pa < 1 || pa > pb) begin errors++; $display("FAIL abort_pulses_after: got %0d want 1..%0d", pa, pb); end
    checks++; if (d !== 1) begin errors++; $display("FAIL abort_done_count: got %0d want 1", d); end
    exp_pos = 24'sd100 + 24'(pb + pa);
    checks++; if (b_pos !== exp_pos) begin errors++; $display("FAIL abort_position: got %0d want %0d", b_pos, exp_pos); end
    checks++; if (b_busy !== 1'b0 || b_vel !== 8'd0) begin errors++; $display("FAIL abort_idle_after: got busy=%b vel=%0d want 0 0", b_busy, b_vel); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++; if (b_busy !== 1'b0 || b_done !== 1'b0 || b_ready !== 1'b1 || b_step !== 1'b0) begin errors++; $display("FAIL abort_in_idle: got busy=%b done=%b ready=%b step=%b want 0 0 1 0", b_busy, b_done, b_ready, b_step); end
    checks++; if (b_pos !== exp_pos) begin errors++; $display("FAIL abort_idle_pos: got %0d want %0d", b_pos, exp_pos); end
  endtask

  task automatic test_reset_mid_move();
    int p = 0, d, f, l, da, g;
    send(1'b1, 16'sd100, 8'd200);
    for (int k = 0; k < 40; k++) cyc();
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", b_busy); end
    rst = 1'b1;
    cyc();
    checks++; if ({b_busy, b_step, b_dir, b_done, b_ready} !== 5'b00001) begin errors++; $display("FAIL rmid_ctrl: got %b want 00001", {b_busy, b_step, b_dir, b_done, b_ready}); end
    checks++; if (b_vel !== 8'd0 || b_pos !== 24'sd0) begin errors++; $display("FAIL rmid_vel_pos: got vel=%0d pos=%0d want 0 0", b_vel, b_pos); end
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (b_step) p++;
    end
    checks++; if (p !== 0) begin errors++; $display("FAIL rmid_no_pulses: got %0d want 0", p); end
    send(1'b1, 16'sd3, 8'd50);
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL rmid_accept: got busy=%b want 1", b_busy); end
    run_until_done(1'b1, 5000, p, d, f, l, da, g);
    checks++; if (p !== 3 || d !== 1) begin errors++; $display("FAIL rmid_new_move: got pulses=%0d dones=%0d want 3 1", p, d); end
    checks++; if (b_pos !== 24'sd3) begin errors++; $display("FAIL rmid_position: got %0d want 3", b_pos); end
  endtask

  initial begin
    test_reset();
    test_positive_move();
    test_negative_move();
    test_zero_move();
    test_profile();
    test_abort();
    test_reset_mid_move();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
